// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package ex_muldiv_unit_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } opCodeT;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } stateT;

    function automatic logic isDivOp(input logic [1:0] op);
        return (opCodeT'(op) == OP_DIV) || (opCodeT'(op) == OP_DIVU);
    endfunction

    function automatic logic isSignedOp(input logic [1:0] op);
        return (opCodeT'(op) == OP_MULT) || (opCodeT'(op) == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a 2*WIDTH accumulator.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               divMode,
    output logic [2*WIDTH-1:0] accNext,
    output logic               qBit
);

    logic [WIDTH:0]   addSum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        addSum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        fits    = (shifted >= {1'b0, operand});
        // When the trial subtraction fits, the true difference is below 2^WIDTH.
        diff    = shifted[WIDTH-1:0] - operand;
        qBit    = 1'b0;
        accNext = '0;
        if (divMode) begin
            qBit    = fits;
            accNext = {(fits ? diff : shifted[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
        end else begin
            accNext = {addSum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage iterative MULT/MULTU/DIV/DIVU unit holding results in HI/LO.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbgState
);

    // Handshake: start is taken only when idle, not flushed and not in the done cycle;
    // busy stays high from acceptance until the cycle done pulses; done lasts one cycle.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    stateT              state;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand;
    logic               divMode;
    logic               negResult;
    logic               negRem;
    logic               divZero;

    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic               accept;
    logic [2*WIDTH-1:0] stepAcc;
    logic               stepQ;
    logic [WIDTH-1:0]   fixHi;
    logic [WIDTH-1:0]   fixLo;

    assign dbgState = state;

    always_comb begin
        absA   = (isSignedOp(op) && srcA[WIDTH-1]) ? -srcA : srcA;
        absB   = (isSignedOp(op) && srcB[WIDTH-1]) ? -srcB : srcB;
        accept = (state == ST_IDLE) && start && !flush && !done;
    end

    muldiv_step #(.WIDTH(WIDTH)) uStep (
        .acc    (acc),
        .operand(operand),
        .divMode(divMode),
        .accNext(stepAcc),
        .qBit   (stepQ)
    );

    // Divide-by-zero leaves |srcA| as remainder, so the dividend-sign fix restores srcA.
    always_comb begin
        fixHi = '0;
        fixLo = '0;
        if (!divMode) begin
            {fixHi, fixLo} = negResult ? -acc : acc;
        end else begin
            fixLo = divZero ? '1
                  : (negResult ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
            fixHi = negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            count     <= '0;
            acc       <= '0;
            operand   <= '0;
            divMode   <= 1'b0;
            negResult <= 1'b0;
            negRem    <= 1'b0;
            divZero   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_RUN;
                        busy      <= 1'b1;
                        count     <= CNT_LOAD;
                        divMode   <= isDivOp(op);
                        negResult <= isSignedOp(op) && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                        negRem    <= isSignedOp(op) && srcA[WIDTH-1];
                        divZero   <= isDivOp(op) && (srcB == '0);
                        acc       <= {{WIDTH{1'b0}}, (isDivOp(op) ? absA : absB)};
                        operand   <= isDivOp(op) ? absB : absA;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc   <= {stepAcc[2*WIDTH-1:1], stepAcc[0] | stepQ};
                        count <= count - CNT_ONE;
                        if (count == CNT_ONE) begin
                            state <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        hi   <= fixHi;
                        lo   <= fixLo;
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed and randomized checks of ex_muldiv_unit against a plain-arithmetic HI/LO model.
module tb_ex_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         flush;
    logic [1:0]   op;
    logic [W-1:0] srcA;
    logic [W-1:0] srcB;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [1:0]   dbgState;

    int checks   = 0;
    int failures = 0;
    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   lastHi = '0;
    logic [W-1:0]   lastLo = '0;
    int doneSeen;
    logic [W-1:0]   extremes[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h1, 32'h0};

    always #5 clk = ~clk;

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .srcA    (srcA),
        .srcB    (srcB),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .dbgState(dbgState)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {hi, lo} computed with 64-bit host arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, qq, rr;
        logic [63:0] r;
        sa = $signed(a);
        sb = $signed(b);
        r  = '0;
        case (o)
            2'b00: r = sa * sb;
            2'b01: r = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else begin
                    qq = sa / sb;
                    rr = sa % sb;
                    r  = {rr[31:0], qq[31:0]};
                end
            end
            default: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; srcA = a; srcB = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Runs one op to completion; poke >= 0 injects a stray start that many cycles in.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int poke);
        int n = 0;
        int busyCnt = 0;
        logic [63:0] e;
        exp_q.push_back(model(o, a, b));
        launch(o, a, b);
        while (!done && n < 100) begin
            busyCnt += int'(busy);
            if (n == poke) begin
                op = ~o; srcA = $urandom; srcB = $urandom; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check("latency", 64'(n), 64'd33);
        check("busy_cycles", 64'(busyCnt), 64'd33);
        check("busy_low_at_done", 64'(busy), 64'd0);
        e = exp_q.pop_front();
        check("hi", 64'(hi), 64'(e[63:32]));
        check("lo", 64'(lo), 64'(e[31:0]));
        lastHi = e[63:32];
        lastLo = e[31:0];
        op = 2'($urandom); srcA = $urandom; srcB = $urandom; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_in_done_cycle", 64'(busy), 64'd0);
        check("hold_after_done", {hi, lo}, e);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; srcA = '0; srcB = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, -1);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1);
        run_op(2'b11, 32'd100, 32'd0, -1);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, -1);
        run_op(2'b11, 32'd1000, 32'd7, 5);

        op = 2'b00; srcA = 32'd5; srcB = 32'd5; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("start_with_flush_idle", 64'(busy), 64'd0);
        check("start_with_flush_hold", {hi, lo}, {lastHi, lastLo});

        launch(2'b11, 32'd10, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_run_busy", 64'(busy), 64'd0);
        check("flush_run_done", 64'(done), 64'd0);
        check("flush_run_hilo", {hi, lo}, {lastHi, lastLo});
        doneSeen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) doneSeen++;
        end
        check("flush_run_no_done", 64'(doneSeen), 64'd0);
        check("flush_run_hold", {hi, lo}, {lastHi, lastLo});

        launch(2'b01, 32'd12345, 32'd6789);
        repeat (32) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_fix_busy", 64'(busy), 64'd0);
        check("flush_fix_done", 64'(done), 64'd0);
        check("flush_fix_hilo", {hi, lo}, {lastHi, lastLo});
        @(posedge clk); #1;

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin
                    ra = 32'($urandom_range(0, 200)) - 32'd100;
                    rb = 32'($urandom_range(0, 40)) - 32'd20;
                end
                2: begin ra = $urandom; rb = 32'd0; end
                default: begin
                    ra = extremes[$urandom_range(0, 4)];
                    rb = extremes[$urandom_range(0, 4)];
                end
            endcase
            run_op(ro, ra, rb, -1);
        end

        launch(2'b00, $urandom, $urandom);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_hi", 64'(hi), 64'd0);
        check("rst_mid_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        lastHi = '0;
        lastLo = '0;
        @(posedge clk); #1;
        run_op(2'b01, 32'd3, 32'd5, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
